pipeline_stage_ctl: RTL and testbench

PIPELINE_STAGE_CTL -- requirements
Module: pipeline_stage_ctl

---
 rtl/pipeline_stage_ctl_if.sv | 33 +++
 rtl/pipeline_stage_ctl.sv | 81 ++++++++
 tb/tb_pipeline_stage_ctl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_ctl_if.sv
// Bundle of the instruction-carrying, pipeline-control and hazard-query signals
// of one pipeline stage controller.
interface pipeline_stage_ctl_if #(
    parameter int WA_W   = 5,
    parameter int CTRL_W = 3
);
    logic              valid_in;
    logic              reg_we_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [WA_W-1:0]   wa_in;
    logic              stall;
    logic              flush;
    logic [WA_W-1:0]   ra0;
    logic [WA_W-1:0]   ra1;

    logic              valid_out;
    logic              reg_we_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [WA_W-1:0]   wa_out;
    logic              hazard0;
    logic              hazard1;
    logic [2:0]        occupancy;

    modport master (
        output valid_in, reg_we_in, ctrl_in, wa_in, stall, flush, ra0, ra1,
        input  valid_out, reg_we_out, ctrl_out, wa_out, hazard0, hazard1, occupancy
    );

    modport slave (
        input  valid_in, reg_we_in, ctrl_in, wa_in, stall, flush, ra0, ra1,
        output valid_out, reg_we_out, ctrl_out, wa_out, hazard0, hazard1, occupancy
    );
endinterface

// File: rtl/pipeline_stage_ctl.sv
// DEPTH-slot instruction shift pipeline with stall/flush control, write-after
// hazard detection against two source addresses, and a valid-slot count.
module pipeline_stage_ctl #(
    parameter int DEPTH  = 3,
    parameter int WA_W   = 5,
    parameter int CTRL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_stage_ctl_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic              reg_we;
        logic [CTRL_W-1:0] ctrl;
        logic [WA_W-1:0]   wa;
    } slot_t;

    slot_t            slot_reg [DEPTH];
    logic [DEPTH-1:0] hit0;
    logic [DEPTH-1:0] hit1;
    logic [2:0]       occ_count;
    slot_t            tail;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            slot_t feed;
            slot_t slot_next;

            if (gi == 0) begin : g_head
                assign feed = {bus.valid_in, bus.reg_we_in, bus.ctrl_in, bus.wa_in};
            end else begin : g_body
                assign feed = slot_reg[gi-1];
            end

            // Flush only drops the valid bit; stale fields are harmless because
            // every consumer qualifies them with valid.
            always_comb begin
                slot_next = slot_reg[gi];
                if (bus.flush) begin
                    slot_next.valid = 1'b0;
                end else if (!bus.stall) begin
                    slot_next = feed;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    slot_reg[gi] <= '0;
                end else begin
                    slot_reg[gi] <= slot_next;
                end
            end

            assign hit0[gi] = slot_reg[gi].valid && slot_reg[gi].reg_we
                              && (slot_reg[gi].wa == bus.ra0);
            assign hit1[gi] = slot_reg[gi].valid && slot_reg[gi].reg_we
                              && (slot_reg[gi].wa == bus.ra1);
        end
    endgenerate

    always_comb begin
        occ_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_count = occ_count + {2'b00, slot_reg[i].valid};
        end
    end

    assign tail = slot_reg[DEPTH-1];

    assign bus.valid_out  = tail.valid;
    assign bus.reg_we_out = tail.valid & tail.reg_we;
    assign bus.ctrl_out   = tail.valid ? tail.ctrl : '0;
    assign bus.wa_out     = tail.wa;
    assign bus.occupancy  = occ_count;

    // Register 0 is hardwired to zero, so a pending write to it is never a hazard.
    assign bus.hazard0 = (|hit0) && (bus.ra0 != '0);
    assign bus.hazard1 = (|hit1) && (bus.ra1 != '0);
endmodule

// File: tb/tb_pipeline_stage_ctl.sv
// Drives DEPTH=3, 1 and 4 instances with one shared stimulus stream; each has a
// scoreboard of in-flight instructions with due cycles checked by a monitor.
module tb_pipeline_stage_ctl;
    typedef struct {
        logic       we;
        logic [2:0] ctrl;
        logic [4:0] wa;
        int         due;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic       reg_we_in = 1'b0;
    logic [2:0] ctrl_in = '0;
    logic [4:0] wa_in = '0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] ra0 = '0;
    logic [4:0] ra1 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int D = (gi == 0) ? 3 : ((gi == 1) ? 1 : 4);

            pipeline_stage_ctl_if #(.WA_W(5), .CTRL_W(3)) bus ();
            assign bus.valid_in  = valid_in;
            assign bus.reg_we_in = reg_we_in;
            assign bus.ctrl_in   = ctrl_in;
            assign bus.wa_in     = wa_in;
            assign bus.stall     = stall;
            assign bus.flush     = flush;
            assign bus.ra0       = ra0;
            assign bus.ra1       = ra1;

            pipeline_stage_ctl #(.DEPTH(D), .WA_W(5), .CTRL_W(3)) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            item_t sb[$];
            item_t held;
            bit    held_v = 1'b0;
            int    cyc = 0;
            int    peak = 0;
            int    occ_m;
            bit    h0_m;
            bit    h1_m;

            // Reference: an accepted instruction is due at the output D-1 edges
            // after it enters, plus one edge for every stall; flush/reset drop all.
            always @(posedge clk) begin
                #1;
                cyc++;
                if (!rst || flush) begin
                    sb.delete();
                    held_v = 1'b0;
                end else if (stall) begin
                    foreach (sb[i]) sb[i].due = sb[i].due + 1;
                end else begin
                    held_v = 1'b0;
                    if (valid_in)
                        sb.push_back('{we: reg_we_in, ctrl: ctrl_in, wa: wa_in, due: cyc + D - 1});
                end
            end

            always @(negedge clk) begin
                if (!rst) begin
                    chk($sformatf("d%0d_rst_valid_out", D), int'(bus.valid_out), 0);
                    chk($sformatf("d%0d_rst_wa_out", D), int'(bus.wa_out), 0);
                    chk($sformatf("d%0d_rst_occupancy", D), int'(bus.occupancy), 0);
                    chk($sformatf("d%0d_rst_hazards", D), int'({bus.hazard0, bus.hazard1}), 0);
                end else begin
                    if (bus.valid_out) begin
                        if (!held_v) begin
                            if (sb.size() == 0) begin
                                n_cmp++;
                                n_bad++;
                                $display("FAIL d%0d_unexpected_out: got wa %0d expected no instruction", D, bus.wa_out);
                            end else begin
                                held = sb.pop_front();
                                held_v = 1'b1;
                                chk($sformatf("d%0d_arrival_cycle", D), cyc, held.due);
                            end
                        end
                        if (held_v) begin
                            chk($sformatf("d%0d_wa_out", D), int'(bus.wa_out), int'(held.wa));
                            chk($sformatf("d%0d_reg_we_out", D), int'(bus.reg_we_out), int'(held.we));
                            chk($sformatf("d%0d_ctrl_out", D), int'(bus.ctrl_out), int'(held.ctrl));
                        end
                    end else begin
                        chk($sformatf("d%0d_held_lost", D), int'(held_v), 0);
                        if (sb.size() > 0)
                            chk($sformatf("d%0d_overdue", D), int'(sb[0].due > cyc), 1);
                        chk($sformatf("d%0d_gated_we", D), int'(bus.reg_we_out), 0);
                        chk($sformatf("d%0d_gated_ctrl", D), int'(bus.ctrl_out), 0);
                    end
                    occ_m = sb.size() + (held_v ? 1 : 0);
                    h0_m = held_v && held.we && (held.wa == ra0) && (ra0 != 0);
                    h1_m = held_v && held.we && (held.wa == ra1) && (ra1 != 0);
                    foreach (sb[i]) begin
                        if (sb[i].we && sb[i].wa == ra0 && ra0 != 0) h0_m = 1'b1;
                        if (sb[i].we && sb[i].wa == ra1 && ra1 != 0) h1_m = 1'b1;
                    end
                    chk($sformatf("d%0d_occupancy", D), int'(bus.occupancy), occ_m);
                    chk($sformatf("d%0d_hazard0", D), int'(bus.hazard0), int'(h0_m));
                    chk($sformatf("d%0d_hazard1", D), int'(bus.hazard1), int'(h1_m));
                    if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
                end
            end
        end
    endgenerate

    task automatic drive(input bit v, input bit we, input logic [2:0] c, input logic [4:0] w,
                         input bit st, input bit fl);
        valid_in  = v;
        reg_we_in = we;
        ctrl_in   = c;
        wa_in     = w;
        stall     = st;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst = 1'b0;
        // Inputs are ignored while reset is held.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 3'($urandom), 5'($urandom_range(1, 7)), 1'b0, 1'b0);
        chk("rst_hold_valid_out", int'(g_dut[0].bus.valid_out), 0);
        chk("rst_hold_occupancy", int'(g_dut[0].bus.occupancy), 0);
        rst = 1'b1;
        idle(1);

        // Back-to-back stream 7,8,9.
        drive(1'b1, 1'b1, 3'b101, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'b101, 5'd8, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'b101, 5'd9, 1'b0, 1'b0);
        idle(5);

        // Single instruction delayed by a two-cycle stall.
        drive(1'b1, 1'b1, 3'b010, 5'd4, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 3'b111, 5'd12, 1'b1, 1'b0);
            chk("stall_occupancy", int'(g_dut[0].bus.occupancy), 1);
        end
        idle(6);

        // Fill, then stall and flush together.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 3'b011, 5'(10 + i), 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'b011, 5'd20, 1'b1, 1'b1);
        chk("flush_occupancy", int'(g_dut[0].bus.occupancy), 0);
        chk("flush_valid_out", int'(g_dut[0].bus.valid_out), 0);
        chk("flush_reg_we_out", int'(g_dut[0].bus.reg_we_out), 0);
        chk("flush_ctrl_out", int'(g_dut[0].bus.ctrl_out), 0);
        idle(2);

        // Hazard query: wa5/we1, wa6/we0 valid, plus an invalid slot with wa9.
        drive(1'b0, 1'b1, 3'd0, 5'd9, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 5'd6, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'd0, 5'd5, 1'b0, 1'b0);
        stall = 1'b1;
        valid_in = 1'b0;
        ra0 = 5'd5; ra1 = 5'd6;
        #1 chk("haz_ra0_5", int'(g_dut[0].bus.hazard0), 1);
        chk("haz_ra1_6_no_we", int'(g_dut[0].bus.hazard1), 0);
        ra0 = 5'd9;
        #1 chk("haz_ra0_9_invalid", int'(g_dut[0].bus.hazard0), 0);
        drive(1'b1, 1'b1, 3'd0, 5'd0, 1'b0, 1'b0);
        stall = 1'b1;
        ra0 = 5'd0; ra1 = 5'd5;
        #1 chk("haz_ra0_zero", int'(g_dut[0].bus.hazard0), 0);
        chk("haz_ra1_5", int'(g_dut[0].bus.hazard1), 1);
        drive(1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 1'b1);
        idle(2);

        // Asynchronous reset with two instructions in flight.
        drive(1'b1, 1'b1, 3'b110, 5'd1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'b110, 5'd2, 1'b0, 1'b0);
        ra0 = 5'd1; ra1 = 5'd2;
        rst = 1'b0;
        #1;
        chk("arst_valid_out", int'(g_dut[0].bus.valid_out), 0);
        chk("arst_reg_we_out", int'(g_dut[0].bus.reg_we_out), 0);
        chk("arst_ctrl_out", int'(g_dut[0].bus.ctrl_out), 0);
        chk("arst_wa_out", int'(g_dut[0].bus.wa_out), 0);
        chk("arst_hazards", int'({g_dut[0].bus.hazard0, g_dut[0].bus.hazard1}), 0);
        chk("arst_occupancy", int'(g_dut[0].bus.occupancy), 0);
        drive(1'b1, 1'b1, 3'b001, 5'd3, 1'b0, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 3'b111, 5'd3, 1'b0, 1'b0);
            chk("post_rst_valid_out", int'(g_dut[0].bus.valid_out), 0);
        end

        // Unstalled run to saturate every depth.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'(i), 3'(i), 5'(i + 1), 1'b0, 1'b0);
        idle(5);

        // Randomized traffic with occasional flushes and reset pulses.
        for (int i = 0; i < 400; i++) begin
            ra0 = 5'($urandom_range(0, 7));
            ra1 = 5'($urandom_range(0, 7));
            rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            drive(1'($urandom), 1'($urandom), 3'($urandom), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
        end
        rst = 1'b1;
        idle(6);

        chk("peak_occ_d3", g_dut[0].peak, 3);
        chk("peak_occ_d1", g_dut[1].peak, 1);
        chk("peak_occ_d4", g_dut[2].peak, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
